// File: rtl/useq_loader.sv
// Program-memory front end for the useq microsequencer: 256x8 store, framed byte-stream loader, core reset hold.
// Optional inter-byte timeout enabled by defining USEQ_LOADER_TIMEOUT_EN.
module useq_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       core_rst_n,
  output logic       busy,
  output logic       loaded,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_RUN
  } state_t;

  state_t     state;
  logic [8:0] cnt;
  logic [7:0] ptr;
  logic [7:0] sum;
  logic [7:0] mem [256];
  logic       accept;
  logic       wr_en;
  logic       timeout_hit;

  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  function automatic logic chk_ok(input logic [7:0] acc, input logic [7:0] chk);
    return sum_add(acc, chk) == 8'd0;
  endfunction

  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && (state == S_DATA);
  assign busy     = (state == S_LEN) || (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  assign mem_data = mem[mem_addr];

`ifdef USEQ_LOADER_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] to_cnt;

  // Idle cycles since the last accepted byte; only meaningful mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (accept || !busy) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 20'd1;
    end
  end

  assign timeout_hit = busy && !accept && (to_cnt == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Store has no reset so a failed or interrupted load leaves contents as-is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      sum        <= '0;
      in_ready   <= 1'b0;
      core_rst_n <= 1'b0;
      loaded     <= 1'b0;
      error      <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      if (accept) begin
        case (state)
          S_IDLE, S_RUN: begin
            if (in_data == SYNC_BYTE) begin
              state      <= S_LEN;
              sum        <= '0;
              error      <= 1'b0;
              core_rst_n <= 1'b0;
              loaded     <= 1'b0;
            end
          end
          S_LEN: begin
            cnt   <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            sum   <= sum_add(sum, in_data);
            state <= S_ADDR;
          end
          S_ADDR: begin
            ptr   <= in_data;
            sum   <= sum_add(sum, in_data);
            state <= S_DATA;
          end
          S_DATA: begin
            ptr <= ptr + 8'd1;
            cnt <= cnt - 9'd1;
            sum <= sum_add(sum, in_data);
            if (cnt == 9'd1) state <= S_CHK;
          end
          S_CHK: begin
            if (chk_ok(sum, in_data)) begin
              state      <= S_RUN;
              core_rst_n <= 1'b1;
              loaded     <= 1'b1;
            end else begin
              state <= S_IDLE;
              error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (timeout_hit) begin
        state <= S_IDLE;
        error <= 1'b1;
      end
    end
  end

endmodule
